// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32 datapath and its controller.
// master = datapath side, slave = controller side.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               zero;
  logic               pcen;
  logic               adrsrc;
  logic               memwrite;
  logic               irwrite;
  logic               regwrite;
  logic [1:0]         resultsrc;
  logic [1:0]         alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         immsrc;
  logic [3:0]         alucontrol;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    output op, funct3, funct7, zero,
    input  pcen, adrsrc, memwrite, irwrite, regwrite,
    input  resultsrc, alusrca, alusrcb, immsrc,
    input  alucontrol, illegal, state
  );

  modport slave (
    input  op, funct3, funct7, zero,
    output pcen, adrsrc, memwrite, irwrite, regwrite,
    output resultsrc, alusrca, alusrcb, immsrc,
    output alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-ALU multicycle RV32 datapath.
// Define MC_ILLEGAL_TRAP_EN to trap undefined opcodes in a sticky TRAP state.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_EXECI    = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_BRANCH   = STATE_W'(9),
    S_JAL      = STATE_W'(10),
    S_LUI      = STATE_W'(11),
    S_TRAP     = STATE_W'(12)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_adrsrc;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_immsrc;
  logic [3:0] w_alucontrol;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       w_illegal;
`endif
  logic       w_unused;

  assign w_unused = ^{bus.funct7[6], bus.funct7[4:0]};

  // State register; reset restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next state and per-state control word
  always_comb begin
    w_next       = S_FETCH;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_adrsrc     = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_resultsrc  = 2'b00;
    w_alusrca    = 2'b00;
    w_alusrcb    = 2'b00;
    w_immsrc     = 3'b000;
    w_alucontrol = 4'b0000;
`ifdef MC_ILLEGAL_TRAP_EN
    w_illegal    = 1'b0;
`endif
    unique case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_pcwrite   = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        w_immsrc  = (bus.op == 7'b1101111) ? 3'b011 : 3'b010;
        case (bus.op)
          7'b0000011,
          7'b0100011: w_next = S_MEMADR;
          7'b0110011: w_next = S_EXECR;
          7'b0010011: w_next = S_EXECI;
          7'b1100011: w_next = S_BRANCH;
          7'b1101111: w_next = S_JAL;
          7'b0110111: w_next = S_LUI;
`ifdef MC_ILLEGAL_TRAP_EN
          default:    w_next = S_TRAP;
`else
          default:    w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_immsrc  = bus.op[5] ? 3'b001 : 3'b000;
        w_next    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        w_alusrca    = 2'b10;
        w_alucontrol = {bus.funct7[5], bus.funct3};
        w_next       = S_ALUWB;
      end
      S_EXECI: begin
        w_alusrca    = 2'b10;
        w_alusrcb    = 2'b01;
        w_alucontrol = {1'b0, bus.funct3};
        w_next       = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca    = 2'b10;
        w_alucontrol = 4'b1000;
        w_branch     = 1'b1;
      end
      S_JAL: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_LUI: begin
        w_resultsrc = 2'b11;
        w_regwrite  = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign bus.pcen       = ~reset &
                          (w_pcwrite |
                           (w_branch & (bus.zero ^ bus.funct3[0])));
  assign bus.memwrite   = ~reset & w_memwrite;
  assign bus.irwrite    = ~reset & w_irwrite;
  assign bus.regwrite   = ~reset & w_regwrite;
  assign bus.adrsrc     = w_adrsrc;
  assign bus.resultsrc  = w_resultsrc;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.immsrc     = w_immsrc;
  assign bus.alucontrol = w_alucontrol;
  assign bus.state      = r_state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal    = ~reset & w_illegal;
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule
